nes_pad_reader: RTL

- Sequences the serial NES controller protocol: generates latch and clock pulses, samples the pad's serial data line, and presents a debounced-per-frame, active-high 8-button word.
- One read is started per frame, normally by the vsync-derived strobe.
- Its up/down/left/right outputs feed the sprite datapath's horizontal and vertical shift counters.
- It owns all pad timing, so the sprite logic only ever sees stable button levels.

---
 rtl/nes_pad_reader_pkg.sv | 29 ++
 rtl/nes_pad_reader_tick_timer.sv | 45 ++++
 rtl/nes_pad_reader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_reader_pkg.sv
// ---------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES controller reader:
//   - bit positions of each button inside the 8-bit button word
//   - FSM state encoding used by nes_pad_reader
// ---------------------------------------------------------------------------
package nes_pkg;

    // Button positions, in the order the pad shifts them out (A first).
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NUM_BUTTONS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage : nes_pkg

// File: rtl/nes_pad_reader_tick_timer.sv
// ---------------------------------------------------------------------------
// nes_tick_timer
// Loadable down-counter that times each protocol phase.
//   clk      : system clock
//   srst     : synchronous active-high reset (count cleared)
//   load     : load load_val this cycle (has priority over counting)
//   load_val : phase length minus one
//   tc       : terminal count, high while the count is zero, i.e. on the
//              last cycle of the phase that was loaded
// A phase of N cycles is obtained by loading N-1 on the cycle before the
// phase starts; the counter then sits at zero (tc) on the phase's last cycle.
// ---------------------------------------------------------------------------
module nes_tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule : nes_tick_timer

// File: rtl/nes_pad_reader.sv
// ---------------------------------------------------------------------------
// nes_pad_reader
// Runs one serial read of an NES pad per accepted start request and
// publishes the result as an active-high 8-button word.
//   inputclk  : system clock
//   reset     : synchronous active-high reset, aborts any read in progress
//   start     : one-cycle read request, honoured only while idle
//   pad_data  : serial data from the pad (active-low, asynchronous)
//   pad_latch : latch pulse to the pad
//   pad_clk   : shift clock to the pad
//   buttons   : last complete button word ([0]=A ... [7]=Right)
//   up/down/left/right : aliases of buttons[4..7]
//   valid     : one-cycle pulse on the cycle buttons updates
//   busy      : read in progress
// Read timing: latch high for LATCH_TICKS*TICK cycles, then eight
// low/high pad_clk periods of TICK cycles each; a bit is sampled on the
// last cycle of every low half, so the pad has had a full half-period to
// settle after the preceding rising edge.
// ---------------------------------------------------------------------------
module nes_pad_reader
    import nes_pkg::*;
#(
    parameter int TICK        = 300,
    parameter int LATCH_TICKS = 2
) (
    input  logic       inputclk,
    input  logic       reset,
    input  logic       start,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       valid,
    output logic       busy
);

    localparam int LATCH_CYCLES = LATCH_TICKS * TICK;
    // The latch phase is the longest phase, so it sizes the timer.
    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LOAD  = CNT_W'(TICK - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous pad data line. Resets to
    // the line's idle (released) level.
    // ------------------------------------------------------------------
    logic pad_meta_q;
    logic pad_sync_q;

    always_ff @(posedge inputclk) begin
        if (reset) begin
            pad_meta_q <= 1'b1;
            pad_sync_q <= 1'b1;
        end else begin
            pad_meta_q <= pad_data;
            pad_sync_q <= pad_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Phase timer
    // ------------------------------------------------------------------
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;

    nes_tick_timer #(
        .WIDTH (CNT_W)
    ) u_tick_timer (
        .clk      (inputclk),
        .srst     (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_e     state_q,     state_d;
    logic       pad_latch_q, pad_latch_d;
    logic       pad_clk_q,   pad_clk_d;
    logic [7:0] buttons_q,   buttons_d;
    logic       valid_q,     valid_d;
    logic       busy_q,      busy_d;
    logic [2:0] bit_idx_q,   bit_idx_d;
    logic [7:0] shift_q,     shift_d;

    always_comb begin
        state_d     = state_q;
        pad_latch_d = pad_latch_q;
        pad_clk_d   = pad_clk_q;
        buttons_d   = buttons_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tmr_load    = 1'b0;
        tmr_val     = TICK_LOAD;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LATCH;
                    pad_latch_d = 1'b1;
                    busy_d      = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = LATCH_LOAD;
                end
            end

            LATCH: begin
                if (tmr_tc) begin
                    state_d     = LOW;
                    pad_latch_d = 1'b0;
                    bit_idx_d   = 3'd0;
                    tmr_load    = 1'b1;
                end
            end

            LOW: begin
                if (tmr_tc) begin
                    // Pad data is active-low; store pressed as 1.
                    shift_d[bit_idx_q] = ~pad_sync_q;
                    state_d            = HIGH;
                    pad_clk_d          = 1'b1;
                    tmr_load           = 1'b1;
                end
            end

            HIGH: begin
                if (tmr_tc) begin
                    pad_clk_d = 1'b0;
                    if (bit_idx_q == 3'd7) begin
                        // Outputs of the DONE cycle are set up here so that
                        // they appear, registered, exactly in that cycle.
                        state_d   = DONE;
                        buttons_d = shift_q;
                        valid_d   = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d   = LOW;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tmr_load  = 1'b1;
                    end
                end
            end

            DONE: begin
                // A start seen here is dropped; only IDLE accepts requests.
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                pad_latch_d = 1'b0;
                pad_clk_d   = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge inputclk) begin
        if (reset) begin
            state_q     <= IDLE;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b0;
            buttons_q   <= 8'h00;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
            buttons_q   <= buttons_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

    assign up    = buttons_q[BTN_UP];
    assign down  = buttons_q[BTN_DOWN];
    assign left  = buttons_q[BTN_LEFT];
    assign right = buttons_q[BTN_RIGHT];

endmodule : nes_pad_reader
